// File: rtl/io_uart.sv
// io_uart: memory-mapped UART on the IO bus. One bank of eight registers,
// a small TX FIFO feeding a serialiser, and a one-byte RX holding buffer.
module io_uart #(
   parameter int unsigned BANK        = 0,
   parameter int unsigned TX_DEPTH    = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pause,
   input  logic [4:0] io_readaddr,
   output logic [7:0] io_readdata,
   input  logic [4:0] io_writeaddr,
   input  logic [7:0] io_writedata,
   input  logic       io_write_en,
   output logic       irq_rx,
   output logic       irq_tx,
   output logic       txd,
   input  logic       rxd
);

   localparam int unsigned AW = $clog2(TX_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // register file and decode
   logic [3:0]  ctrl_q;        // {tx_ie, rx_ie, rx_en, tx_en}
   logic [15:0] div_q;
   logic        wr_hit;
   logic [2:0]  wr_off;
   logic        rx_ack, err_clr, push_req;
   logic [7:0]  rd_mux, status;
   logic        unused_readbank;

   // TX FIFO
   logic [7:0]  tx_mem [TX_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        tx_empty, tx_full, tx_push, tx_pop;

   // TX serialiser
   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_sh;
   logic        tx_tick, tx_busy;

   // RX deserialiser
   rx_state_t   rx_state, rx_next;
   logic [1:0]  rx_sync;
   logic        rx_s, rx_d, rx_fall;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_sh, rx_buf;
   logic        rx_tick, rx_valid, overrun, frame_err;
   logic        rx_stop_evt, rx_free;

   assign wr_hit   = io_write_en && (io_writeaddr[4:3] == 2'(BANK));
   assign wr_off   = io_writeaddr[2:0];
   assign push_req = wr_hit && (wr_off == 3'd0);
   assign rx_ack   = wr_hit && (wr_off == 3'd2) && io_writedata[4];
   assign err_clr  = wr_hit && (wr_off == 3'd2) && io_writedata[5];

   // bank bits of the read address are checked by the controller
   assign unused_readbank = ^io_readaddr[4:3];

   assign tx_empty = (wr_ptr == rd_ptr);
   assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a pop in the same cycle frees a slot, so a push on a full FIFO still lands
   assign tx_push  = push_req && (!tx_full || tx_pop);

   assign status = {2'b00, tx_busy, frame_err, overrun, rx_valid, tx_empty, tx_full};
   assign irq_rx = rx_valid && ctrl_q[2];
   assign irq_tx = tx_empty && ctrl_q[3];

   // control and divisor registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q <= '0;
         div_q  <= DEFAULT_DIV;
      end else if (wr_hit) begin
         case (wr_off)
            3'd2:    ctrl_q       <= io_writedata[3:0];
            3'd3:    div_q[7:0]   <= io_writedata;
            3'd4:    div_q[15:8]  <= io_writedata;
            default: ;
         endcase
      end
   end

   // read mux; reads never have side effects
   always_comb begin
      rd_mux = '0;
      case (io_readaddr[2:0])
         3'd0:    rd_mux = rx_buf;
         3'd1:    rd_mux = status;
         3'd2:    rd_mux = {4'b0000, ctrl_q};
         3'd3:    rd_mux = div_q[7:0];
         3'd4:    rd_mux = div_q[15:8];
         default: rd_mux = '0;
      endcase
   end

   // registered read data, frozen while the pipeline is paused
   always_ff @(posedge clk) begin
      if (reset)       io_readdata <= '0;
      else if (!pause) io_readdata <= rd_mux;
   end

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[wr_ptr[AW-1:0]] <= io_writedata;
   end

   // TX state register
   always_ff @(posedge clk) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;
   end

   assign tx_tick = (tx_cnt == '0);

   // TX next-state
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (ctrl_q[0] && !tx_empty)   tx_next = TX_START;
         TX_START: if (tx_tick)                  tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_tick)                  tx_next = TX_IDLE;
         default:                                tx_next = TX_IDLE;
      endcase
   end

   // TX outputs
   always_comb begin
      tx_pop  = (tx_state == TX_IDLE) && ctrl_q[0] && !tx_empty;
      tx_busy = (tx_state != TX_IDLE);
      case (tx_state)
         TX_START: txd = 1'b0;
         TX_DATA:  txd = tx_sh[0];
         default:  txd = 1'b1;
      endcase
   end

   // TX bit timer and shift register; divisor is re-read at every bit load
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
      end else if (tx_pop) begin
         tx_sh  <= tx_mem[rd_ptr[AW-1:0]];
         tx_cnt <= div_q;
         tx_bit <= '0;
      end else if (tx_state != TX_IDLE) begin
         if (tx_tick) begin
            tx_cnt <= div_q;
            if (tx_state == TX_DATA) begin
               tx_sh  <= {1'b1, tx_sh[7:1]};
               tx_bit <= tx_bit + 3'd1;
            end
         end else begin
            tx_cnt <= tx_cnt - 16'd1;
         end
      end
   end

   // rxd synchroniser plus one stage for falling-edge detect
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync <= 2'b11;
         rx_d    <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rxd};
         rx_d    <= rx_sync[1];
      end
   end

   assign rx_s    = rx_sync[1];
   assign rx_fall = rx_d && !rx_s;
   assign rx_tick = (rx_cnt == '0);

   // RX state register
   always_ff @(posedge clk) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   // RX next-state; dropping rx_en aborts from any state
   always_comb begin
      rx_next = rx_state;
      if (!ctrl_q[1]) begin
         rx_next = RX_IDLE;
      end else begin
         case (rx_state)
            RX_IDLE:  if (rx_fall)                   rx_next = RX_START;
            RX_START: if (rx_tick)                   rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick)                   rx_next = RX_IDLE;
            default:                                 rx_next = RX_IDLE;
         endcase
      end
   end

   // RX outputs: stop-bit sample event and buffer availability
   always_comb begin
      rx_stop_evt = ctrl_q[1] && (rx_state == RX_STOP) && rx_tick;
      // an ack in the same cycle frees the buffer, so the new byte wins
      rx_free     = !rx_valid || rx_ack;
   end

   // RX bit timer and shift register; start bit is timed to its middle
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh  <= '0;
      end else if (rx_state == RX_IDLE) begin
         if (rx_fall) rx_cnt <= div_q >> 1;
      end else if (rx_tick) begin
         rx_cnt <= div_q;
         if (rx_state == RX_START) begin
            rx_bit <= '0;
         end else if (rx_state == RX_DATA) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
         end
      end else begin
         rx_cnt <= rx_cnt - 16'd1;
      end
   end

   // RX buffer and sticky error flags; a new event wins over a clear
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_buf    <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (rx_stop_evt && rx_s && rx_free) begin
            rx_buf   <= rx_sh;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end

         if (rx_stop_evt && rx_s && !rx_free) overrun <= 1'b1;
         else if (err_clr)                    overrun <= 1'b0;

         if (rx_stop_evt && !rx_s) frame_err <= 1'b1;
         else if (err_clr)         frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: directed bench for io_uart with hand-computed expectations.
module tb_io_uart;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pause = 1'b0;
   logic [4:0] io_readaddr = '0;
   logic [7:0] io_readdata;
   logic [4:0] io_writeaddr = '0;
   logic [7:0] io_writedata = '0;
   logic       io_write_en = 1'b0;
   logic       irq_rx, irq_tx, txd;
   logic       rxd = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   io_uart #(.BANK(0), .TX_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
      .clk(clk), .reset(reset), .pause(pause),
      .io_readaddr(io_readaddr), .io_readdata(io_readdata),
      .io_writeaddr(io_writeaddr), .io_writedata(io_writedata),
      .io_write_en(io_write_en),
      .irq_rx(irq_rx), .irq_tx(irq_tx), .txd(txd), .rxd(rxd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic io_write(input logic [2:0] off, input logic [7:0] d);
      io_writeaddr = {2'b00, off};
      io_writedata = d;
      io_write_en  = 1'b1;
      tick(1);
      io_write_en  = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
      io_readaddr = {2'b00, off};
      tick(1);
      check(tag, io_readdata, exp);
   endtask

   // wait for a start bit, then sample each bit at its middle; ends one
   // cycle after the stop bit (4-cycle bits)
   task automatic capture_frame(output logic [7:0] b, output logic stop_bit, output logic timed_out);
      timed_out = 1'b1;
      b = '0;
      stop_bit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (txd == 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
      if (!timed_out) begin
         tick(2);
         for (int j = 0; j < 8; j++) begin
            tick(4);
            b[j] = txd;
         end
         tick(4);
         stop_bit = txd;
         tick(2);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(4);
      end
      rxd = stop_bit;
      tick(4);
      rxd = 1'b1;
      tick(6);
   endtask

   initial begin
      logic [9:0] frame;
      logic [7:0] b;
      logic       sb, to;
      logic [7:0] exp_bytes [4];

      // reset state
      tick(3);
      reset = 1'b0;
      check("reset_txd", txd, 1);
      check("reset_irq_rx", irq_rx, 0);
      check("reset_irq_tx", irq_tx, 0);
      check_reg("reset_data", 3'd0, 8'h00);
      check_reg("reset_status", 3'd1, 8'h02);
      check_reg("reset_ctrl", 3'd2, 8'h00);
      check_reg("reset_divlo", 3'd3, 8'hB1);
      check_reg("reset_divhi", 3'd4, 8'h01);
      check_reg("reset_off5", 3'd5, 8'h00);

      // single TX frame, divisor 3 -> 4 cycles per bit
      io_write(3'd3, 8'h03);
      io_write(3'd4, 8'h00);
      io_write(3'd2, 8'h09);
      check("tx_irq_empty", irq_tx, 1);
      io_write(3'd0, 8'hA5);
      io_readaddr = 5'd1;
      frame = {1'b1, 8'hA5, 1'b0};
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (txd == 1'b0) begin
            to = 1'b0;
            break;
         end
      end
      check("tx_start_seen", to, 0);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check($sformatf("tx_bit%0d_early", k), txd, frame[k]);
         if (k == 0) check("tx_status_busy", io_readdata, 8'h22);
         tick(2);
         check($sformatf("tx_bit%0d_late", k), txd, frame[k]);
         tick(1);
      end
      check_reg("tx_status_done", 3'd1, 8'h02);
      check("tx_irq_after", irq_tx, 1);

      // fill FIFO with tx disabled; fifth byte is dropped
      io_write(3'd2, 8'h00);
      io_write(3'd0, 8'h11);
      io_write(3'd0, 8'h22);
      io_write(3'd0, 8'h33);
      io_write(3'd0, 8'h44);
      io_write(3'd0, 8'h55);
      check_reg("fifo_full_status", 3'd1, 8'h01);
      check("fifo_full_txd_idle", txd, 1);
      exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      io_write(3'd2, 8'h01);
      for (int f = 0; f < 4; f++) begin
         capture_frame(b, sb, to);
         check($sformatf("fifo_frame%0d_timeout", f), to, 0);
         check($sformatf("fifo_frame%0d_byte", f), b, exp_bytes[f]);
         check($sformatf("fifo_frame%0d_stop", f), sb, 1);
      end
      capture_frame(b, sb, to);
      check("fifo_no_fifth_frame", to, 1);
      check_reg("fifo_drained_status", 3'd1, 8'h02);

      // RX a single frame
      io_write(3'd2, 8'h06);
      send_rx(8'h3C, 1'b1);
      check_reg("rx_status_valid", 3'd1, 8'h06);
      check_reg("rx_data", 3'd0, 8'h3C);
      check("rx_irq", irq_rx, 1);
      io_write(3'd2, 8'h16);
      check_reg("rx_ack_status", 3'd1, 8'h02);
      check("rx_irq_cleared", irq_rx, 0);
      check_reg("rx_ctrl_ack_selfclear", 3'd2, 8'h06);

      // overrun, then framing error, then error clear
      send_rx(8'h5A, 1'b1);
      send_rx(8'hC3, 1'b1);
      check_reg("ovr_status", 3'd1, 8'h0E);
      check_reg("ovr_data_kept", 3'd0, 8'h5A);
      send_rx(8'h81, 1'b0);
      check_reg("ferr_status", 3'd1, 8'h1E);
      check_reg("ferr_data_kept", 3'd0, 8'h5A);
      io_write(3'd2, 8'h26);
      check_reg("errclr_status", 3'd1, 8'h06);
      io_write(3'd2, 8'h16);
      check_reg("errclr_ack_status", 3'd1, 8'h02);

      // pause holds io_readdata
      check_reg("pause_pre", 3'd3, 8'h03);
      pause = 1'b1;
      io_readaddr = 5'd4;
      tick(1);
      check("pause_hold1", io_readdata, 8'h03);
      io_readaddr = 5'd1;
      tick(2);
      check("pause_hold2", io_readdata, 8'h03);
      pause = 1'b0;
      io_readaddr = 5'd4;
      tick(1);
      check("pause_release", io_readdata, 8'h00);

      // one-cycle glitch on rxd is rejected and RX still works afterwards
      rxd = 1'b0;
      tick(1);
      rxd = 1'b1;
      tick(10);
      check_reg("glitch_status", 3'd1, 8'h02);
      send_rx(8'h96, 1'b1);
      check_reg("glitch_recover_status", 3'd1, 8'h06);
      check_reg("glitch_recover_data", 3'd0, 8'h96);

      // reset mid-frame returns txd high at once and restores defaults
      io_write(3'd2, 8'h01);
      io_write(3'd0, 8'h00);
      tick(6);
      check("midframe_txd_low", txd, 0);
      reset = 1'b1;
      tick(1);
      check("midframe_reset_txd", txd, 1);
      reset = 1'b0;
      check_reg("midframe_status", 3'd1, 8'h02);
      check_reg("midframe_ctrl", 3'd2, 8'h00);
      check_reg("midframe_divlo", 3'd3, 8'hB1);
      check_reg("midframe_data", 3'd0, 8'h00);
      tick(4);
      check("midframe_txd_idle", txd, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
